// File: rtl/pipeline_hazard_ctrl.sv
// Front-end pipeline sequencer for the 16-bit datapath: load-use stalls, mul/div
// occupancy, taken-branch flushes and HALT, driving PC enable and IF/DF, DF/EX control.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W    = 4,
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] df_rs1,
  input  logic [REG_ADDR_W-1:0] df_rs2,
  input  logic                  df_muldiv,
  input  logic                  df_halt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  if_df_stall,
  output logic                  if_df_flush,
  output logic                  df_ex_bubble,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt
);

  // state   | meaning
  // RUN     | normal issue; resolves branch, halt, mul/div and load-use hazards
  // MD_WAIT | mul/div occupying EX; front end held until md_cnt reaches 0
  // HALT    | core stopped; only rst leaves
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    HALT    = 2'd2
  } state_e;

  // The entry cycle in RUN is one of the MULDIV_CYCLES stall cycles, and the
  // md_cnt==0 cycle in MD_WAIT is another, hence the -2 preload.
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 2);

  state_e           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu_hit;

  assign lu_hit = ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == df_rs1) || (ex_rd == df_rs2));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_write     = 1'b0;
    if_df_stall  = 1'b0;
    if_df_flush  = 1'b0;
    df_ex_bubble = 1'b0;
    halted       = 1'b0;

    if (rst) begin
      if_df_flush  = 1'b1;
      df_ex_bubble = 1'b1;
      state_d      = RUN;
      md_cnt_d     = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            if_df_flush  = 1'b1;
            df_ex_bubble = 1'b1;
            pc_write     = 1'b1;
          end else if (df_halt) begin
            if_df_stall = 1'b1;
            state_d     = HALT;
          end else if (df_muldiv) begin
            if_df_stall = 1'b1;
            md_cnt_d    = MD_LOAD;
            state_d     = MD_WAIT;
          end else if (lu_hit) begin
            if_df_stall  = 1'b1;
            df_ex_bubble = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end

        MD_WAIT: begin
          // A taken branch here is older than the mul/div's successors: abort the wait.
          if (branch_taken) begin
            if_df_flush  = 1'b1;
            df_ex_bubble = 1'b1;
            pc_write     = 1'b1;
            md_cnt_d     = '0;
            state_d      = RUN;
          end else begin
            if_df_stall  = 1'b1;
            df_ex_bubble = 1'b1;
            if (md_cnt_q == '0) begin
              state_d = RUN;
            end else begin
              md_cnt_d = md_cnt_q - 4'd1;
            end
          end
        end

        HALT: begin
          if_df_stall  = 1'b1;
          df_ex_bubble = 1'b1;
          halted       = 1'b1;
        end

        default: begin
          state_d  = RUN;
          md_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
    end else if (if_df_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. CNT_W=4 so stall_cnt saturation is reachable.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] df_rs1, df_rs2, ex_rd;
  logic          df_muldiv, df_halt, ex_mem_read, branch_taken;
  logic          pc_write, if_df_stall, if_df_flush, df_ex_bubble, halted;
  logic [CW-1:0] stall_cnt;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .MULDIV_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .df_rs1(df_rs1), .df_rs2(df_rs2), .df_muldiv(df_muldiv), .df_halt(df_halt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(pc_write), .if_df_stall(if_df_stall), .if_df_flush(if_df_flush),
    .df_ex_bubble(df_ex_bubble), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    outs;   // {pc_write, if_df_stall, if_df_flush, df_ex_bubble, halted}
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [4:0] act;
      e   = exp_q.pop_front();
      act = {pc_write, if_df_stall, if_df_flush, df_ex_bubble, halted};
      n_cmp++;
      if (act !== e.outs) begin
        n_bad++;
        $display("FAIL %s outs{pc,stall,flush,bubble,halted}: got %b want %b", e.name, act, e.outs);
      end
      n_cmp++;
      if (stall_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
      end
    end
  end

  task automatic vec(input logic r, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                     input logic md, input logic hl, input logic mr, input logic [RW-1:0] rd,
                     input logic br, input logic [4:0] outs, input int cnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; df_rs1 = rs1; df_rs2 = rs2; df_muldiv = md; df_halt = hl;
    ex_mem_read = mr; ex_rd = rd; branch_taken = br;
    e.outs = outs;
    e.cnt  = CW'(cnt);
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] outs, input int cnt, input string nm);
    vec(0, 0, 0, 0, 0, 0, 0, 0, outs, cnt, nm);
  endtask

  localparam logic [4:0] O_RUN   = 5'b10000;
  localparam logic [4:0] O_RST   = 5'b00110;
  localparam logic [4:0] O_LU    = 5'b01010;
  localparam logic [4:0] O_ISSUE = 5'b01000;
  localparam logic [4:0] O_WAIT  = 5'b01010;
  localparam logic [4:0] O_FLUSH = 5'b10110;
  localparam logic [4:0] O_HALT  = 5'b01011;

  initial begin
    rst = 1'b1; df_rs1 = '0; df_rs2 = '0; df_muldiv = 1'b0; df_halt = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; branch_taken = 1'b0;
    @(posedge clk);

    vec(1, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, "reset");
    idle(O_RUN, 0, "idle_after_reset");
    vec(0, 0, 3, 0, 0, 1, 3, 0, O_LU, 0, "loaduse_rs2");
    idle(O_RUN, 1, "loaduse_release");
    vec(0, 0, 0, 0, 0, 1, 0, 0, O_RUN, 1, "r0_no_hazard");
    vec(0, 5, 0, 0, 0, 1, 5, 0, O_LU, 1, "loaduse_rs1");
    vec(0, 5, 0, 0, 0, 0, 5, 0, O_RUN, 2, "non_load_no_hazard");
    vec(0, 0, 0, 1, 0, 0, 0, 0, O_ISSUE, 2, "md_issue");
    idle(O_WAIT, 3, "md_wait1");
    idle(O_WAIT, 4, "md_wait2");
    idle(O_WAIT, 5, "md_wait3");
    idle(O_RUN, 6, "md_done_cycle5");
    vec(0, 0, 0, 1, 0, 0, 0, 0, O_ISSUE, 6, "md2_issue");
    idle(O_WAIT, 7, "md2_wait1");
    vec(0, 0, 0, 0, 0, 0, 0, 1, O_FLUSH, 8, "md2_branch_abort");
    idle(O_RUN, 8, "after_abort_run");
    vec(0, 3, 0, 0, 1, 1, 3, 1, O_FLUSH, 8, "branch_over_halt_lu");
    idle(O_RUN, 8, "not_halted_after_flush");
    vec(0, 3, 0, 1, 0, 1, 3, 0, O_ISSUE, 8, "md_over_lu");
    idle(O_WAIT, 9, "md3_wait1");
    vec(1, 0, 0, 0, 0, 0, 0, 0, O_RST, 10, "reset_mid_md");
    idle(O_RUN, 0, "run_after_md_reset");
    idle(O_RUN, 0, "still_run_after_md_reset");
    vec(0, 0, 0, 1, 1, 0, 0, 0, O_ISSUE, 0, "halt_over_md");
    for (int i = 0; i < 20; i++) begin
      vec(0, 0, 0, 0, 0, 0, 0, logic'(i % 2), O_HALT, ((i + 1) > 15) ? 15 : (i + 1), "halt_hold");
    end
    vec(1, 0, 0, 0, 0, 0, 0, 0, O_RST, 15, "reset_from_halt_sat");
    idle(O_RUN, 0, "run_after_halt_reset");

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
